regfile_writeback_arbiter: RTL and testbench

- Owns the single write port (WE3/A3/WD3) of the 32x32 register file.
- Merges two writeback sources:
  - the main ALU/load pipeline: one write per cycle, unbuffered;
  - a multi-cycle mul/div unit: valid/ready handshake, buffered in a small FIFO.
- Also provides scoreboard hazard flags, so decode stalls on any read of a register with a queued write.

---
 rtl/regfile_writeback_arbiter_pkg.sv | 16 +
 rtl/regfile_writeback_arbiter_wb_fifo.sv | 74 +++++++
 rtl/regfile_writeback_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types and constants for the register-file
// writeback path.
package regfile_writeback_arbiter_pkg;

  localparam int REG_ADDRESS_WIDTH = 5;
  localparam int WIDTH             = 32;
  localparam int NO_OF_REG         = 32;

  localparam logic [REG_ADDRESS_WIDTH-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDRESS_WIDTH-1:0] addr;
    logic [WIDTH-1:0]             data;
  } wb_req_t;

endpackage

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
// Mul/div result queue; exposes per-entry valid and
// address so the hazard compare can scan all entries.
module regfile_writeback_arbiter_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [AW-1:0]             i_addr,
  input  logic [DW-1:0]             i_data,
  input  logic                      i_pop,
  output logic [AW-1:0]             o_head_addr,
  output logic [DW-1:0]             o_head_data,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [DEPTH-1:0]          o_valid,
  output logic [DEPTH-1:0][AW-1:0]  o_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0] r_addr;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [PW-1:0]            r_wr;
  logic [PW-1:0]            r_rd;
  logic [PW:0]              r_cnt;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = r_cnt == (PW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_head_addr = r_addr[r_rd];
  assign o_head_data = r_data[r_rd];
  assign o_count     = r_cnt;
  assign o_addr      = r_addr;

  // An entry is live when its distance from the read
  // pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign o_valid[g] =
      {1'b0, PW'(PW'(g) - r_rd)} < r_cnt;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr] <= i_addr;
      r_data[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Single write-port owner for the register file: ALU
// writes direct, mul/div results queued, with hazards.
module regfile_writeback_arbiter #(
  parameter int DEPTH             = 4,
  parameter int REG_ADDRESS_WIDTH = 5,
  parameter int WIDTH             = 32,
  parameter int STARVE_LIMIT      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_we,
  input  logic [REG_ADDRESS_WIDTH-1:0] alu_addr,
  input  logic [WIDTH-1:0]             alu_data,
  output logic                         alu_stall,
  input  logic                         md_valid,
  output logic                         md_ready,
  input  logic [REG_ADDRESS_WIDTH-1:0] md_addr,
  input  logic [WIDTH-1:0]             md_data,
  input  logic [REG_ADDRESS_WIDTH-1:0] rd_a1,
  input  logic [REG_ADDRESS_WIDTH-1:0] rd_a2,
  output logic                         hazard1,
  output logic                         hazard2,
  output logic                         WE3,
  output logic [REG_ADDRESS_WIDTH-1:0] A3,
  output logic [WIDTH-1:0]             WD3
);

  import regfile_writeback_arbiter_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [REG_ADDRESS_WIDTH-1:0] A_ZERO =
    REG_ADDRESS_WIDTH'(ZERO_REG);

  logic                         r_we;
  logic [REG_ADDRESS_WIDTH-1:0] r_a3;
  logic [WIDTH-1:0]             r_wd3;
  logic [SW-1:0]                r_starve;

  logic                         w_alu_req;
  logic                         w_push;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_force;
  logic                         w_gnt_alu;
  logic                         w_gnt_fifo;
  logic [CW-1:0]                w_count;
  logic [REG_ADDRESS_WIDTH-1:0] w_head_addr;
  logic [WIDTH-1:0]             w_head_data;
  logic [DEPTH-1:0]             w_valid;
  logic [DEPTH-1:0][REG_ADDRESS_WIDTH-1:0] w_addrs;
  logic [DEPTH-1:0]             w_hit1;
  logic [DEPTH-1:0]             w_hit2;

  assign w_full    = w_count == CW'(DEPTH);
  assign md_ready  = !w_full;
  assign w_alu_req = alu_we && (alu_addr != A_ZERO);
  // Writes to $0 complete the handshake but are dropped.
  assign w_push    = md_valid && md_ready &&
                     (md_addr != A_ZERO);

  assign w_force    = !w_empty &&
                      (r_starve == SW'(STARVE_LIMIT));
  assign w_gnt_alu  = w_alu_req && !w_force;
  assign w_gnt_fifo = w_force || (!w_alu_req && !w_empty);
  assign alu_stall  = w_force;

  regfile_writeback_arbiter_wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (REG_ADDRESS_WIDTH),
    .DW    (WIDTH)
  ) u_wb_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_addr      (md_addr),
    .i_data      (md_data),
    .i_pop       (w_gnt_fifo),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_valid     (w_valid),
    .o_addr      (w_addrs)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign w_hit1[g] = w_valid[g] && (w_addrs[g] == rd_a1);
    assign w_hit2[g] = w_valid[g] && (w_addrs[g] == rd_a2);
  end

  assign hazard1 = (|w_hit1) && (rd_a1 != A_ZERO);
  assign hazard2 = (|w_hit2) && (rd_a2 != A_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_gnt_fifo) begin
      r_starve <= '0;
    end else if (w_gnt_alu &&
                 r_starve != SW'(STARVE_LIMIT)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else begin
      unique case (1'b1)
        w_gnt_alu: begin
          r_we  <= 1'b1;
          r_a3  <= alu_addr;
          r_wd3 <= alu_data;
        end
        w_gnt_fifo: begin
          r_we  <= 1'b1;
          r_a3  <= w_head_addr;
          r_wd3 <= w_head_data;
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign WE3 = r_we;
  assign A3  = r_a3;
  assign WD3 = r_wd3;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomised scoreboard bench for the writeback arbiter
// against a queue-based reference model.
module tb_regfile_writeback_arbiter;

  import regfile_writeback_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_we = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_addr = '0;
  logic [31:0] md_data = '0;
  logic [4:0]  rd_a1 = '0;
  logic [4:0]  rd_a2 = '0;
  logic        hazard1;
  logic        hazard2;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(
    .DEPTH             (DEPTH),
    .REG_ADDRESS_WIDTH (5),
    .WIDTH             (32),
    .STARVE_LIMIT      (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_we    (alu_we),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_addr   (md_addr),
    .md_data   (md_data),
    .rd_a1     (rd_a1),
    .rd_a2     (rd_a2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3)
  );

  wb_req_t exp_q[$];
  wb_req_t mdl_q[$];
  int      starve = 0;
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h",
               name, act, req);
    end
  endtask

  // Monitor: every write seen on the port must match the
  // oldest outstanding expectation.
  initial begin
    wb_req_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst && WE3 === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got A3=%0d WD3=%h, required no write",
                   A3, WD3);
        end else begin
          e = exp_q.pop_front();
          chk("wb_addr", 32'(A3), 32'(e.addr));
          chk("wb_data", WD3, e.data);
        end
      end
    end
  end

  task automatic step(input logic awe,
                      input logic [4:0] aa,
                      input logic [31:0] ad,
                      input logic mv,
                      input logic [4:0] ma,
                      input logic [31:0] md,
                      input logic [4:0] r1,
                      input logic [4:0] r2);
    bit ready, frc, areq, gf, h1, h2;
    @(negedge clk);
    alu_we   = awe;
    alu_addr = aa;
    alu_data = ad;
    md_valid = mv;
    md_addr  = ma;
    md_data  = md;
    rd_a1    = r1;
    rd_a2    = r2;
    #1;
    ready = mdl_q.size() < DEPTH;
    frc   = mdl_q.size() != 0 && starve == LIMIT;
    h1 = 1'b0;
    h2 = 1'b0;
    foreach (mdl_q[i]) begin
      if (r1 != 0 && mdl_q[i].addr == r1) h1 = 1'b1;
      if (r2 != 0 && mdl_q[i].addr == r2) h2 = 1'b1;
    end
    chk("md_ready", 32'(md_ready), 32'(ready));
    chk("alu_stall", 32'(alu_stall), 32'(frc));
    chk("hazard1", 32'(hazard1), 32'(h1));
    chk("hazard2", 32'(hazard2), 32'(h2));
    areq = awe && aa != 0;
    gf   = frc || (!areq && mdl_q.size() != 0);
    if (gf) exp_q.push_back(mdl_q[0]);
    else if (areq) exp_q.push_back('{addr: aa, data: ad});
    if (mdl_q.size() == 0 || gf) starve = 0;
    else if (starve < LIMIT) starve++;
    if (gf) void'(mdl_q.pop_front());
    if (mv && ready && ma != 0)
      mdl_q.push_back('{addr: ma, data: md});
  endtask

  task automatic idle(input int n, input logic [4:0] r1);
    for (int k = 0; k < n; k++)
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst      = 1'b1;
    alu_we   = 1'b0;
    md_valid = 1'b0;
    #1;
    chk("rst_WE3", 32'(WE3), 32'd0);
    chk("rst_A3", 32'(A3), 32'd0);
    chk("rst_WD3", WD3, 32'd0);
    chk("rst_hazard1", 32'(hazard1), 32'd0);
    mdl_q.delete();
    exp_q.delete();
    starve = 0;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a;
    int p;
    do_reset(3);
    idle(10, 5'd3);

    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,
         5'd0, 5'd0);
    @(posedge clk);
    #1;
    chk("alu_we3_n1", 32'(WE3), 32'd1);
    chk("alu_a3_n1", 32'(A3), 32'd5);
    chk("alu_wd3_n1", WD3, 32'hDEADBEEF);
    idle(1, 5'd0);
    @(posedge clk);
    #1;
    chk("alu_we3_n2", 32'(WE3), 32'd0);
    idle(2, 5'd0);

    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'(10 + i), $urandom, 1'b1, 5'(i),
           $urandom, 5'd1, 5'd4);
    for (int i = 0; i < 10; i++)
      step(1'b1, 5'(20 + i), $urandom, 1'b0, 5'd0,
           32'd0, 5'(i % 5), 5'd2);
    idle(6, 5'd0);

    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777, 5'd7, 5'd0);
    step(1'b1, 5'd8, 32'h8888, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    idle(3, 5'd7);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
    idle(3, 5'd0);

    step(1'b1, 5'd15, 32'hA, 1'b1, 5'd1, 32'h101, 5'd1, 5'd9);
    step(1'b1, 5'd16, 32'hB, 1'b1, 5'd2, 32'h202, 5'd2, 5'd9);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h909, 5'd1, 5'd9);
    idle(5, 5'd9);

    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(17 + i), $urandom, 1'b1, 5'(4 + i),
           $urandom, 5'd4, 5'd6);
    do_reset(2);
    idle(8, 5'd5);

    for (int n = 0; n < 3000; n++) begin
      p = (n / 200) % 3;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                      : 5'($urandom_range(0, 7));
      step(($urandom_range(0, 9) < (p == 0 ? 9 : p == 1 ? 5 : 1)),
           5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 9) < 6), a, $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (n == 1500) do_reset(2);
    end

    for (int k = 0; k < 64 && mdl_q.size() != 0; k++)
      idle(1, 5'd0);
    idle(3, 5'd0);
    chk("model_drained", mdl_q.size(), 32'd0);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
